// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32 instruction encoder feeding a 2-entry write FIFO toward instruction memory.
// Optional macro INSTR_ENC_RANGE_CHECK_EN: drop illegal requests and raise sticky err.
module instr_encoder #(
    parameter int          ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_kind,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [12:0]           imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [31:0]           out_data,
    output logic [15:0]           count,
    output logic                  err
);

    localparam logic [ADDR_WIDTH-1:0] LP_BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [2:0] K_LW = 3'd0, K_SW = 3'd1, K_ADD = 3'd2, K_BNE = 3'd3, K_ADDI = 3'd4;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} occ_t;

    occ_t                  r_state;
    occ_t                  w_state_nxt;
    logic                  r_run;
    logic [31:0]           r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_count;
    logic [31:0]           w_word;
    logic                  w_legal;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_unused;

    // imm[0] only matters for the BNE alignment check.
    assign w_unused = imm[0];

    always_comb begin
        w_word  = 32'h0000_0013;
        w_legal = 1'b1;
        case (in_kind)
            K_LW:   w_word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            K_SW:   w_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            K_ADD:  w_word = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_BNE: begin
                w_word = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                if (imm[0]) begin
                    w_legal = 1'b0;
                end
`endif
            end
            K_ADDI: w_word = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
            default: begin
`ifdef INSTR_ENC_RANGE_CHECK_EN
                w_legal = 1'b0;
`endif
            end
        endcase
    end

    assign in_ready  = r_run && (r_state != S_FULL) && !clear;
    assign out_valid = (r_state != S_EMPTY);
    assign out_data  = r_mem[r_rd_ptr];
    assign out_addr  = r_addr;
    assign count     = r_count;
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && w_legal;
    assign w_pop     = out_valid && out_ready && !clear;

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_push) w_state_nxt = S_ONE;
                S_ONE: begin
                    if (w_push && !w_pop)      w_state_nxt = S_FULL;
                    else if (!w_push && w_pop) w_state_nxt = S_EMPTY;
                end
                S_FULL:  if (w_pop) w_state_nxt = S_ONE;
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_EMPTY;
            r_run    <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_addr   <= LP_BASE;
            r_count  <= 16'h0000;
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
            if (clear) begin
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
                r_addr   <= LP_BASE;
                r_count  <= 16'h0000;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= w_word;
                    r_wr_ptr        <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                    r_addr   <= r_addr + 1'b1;
                    if (r_count != 16'hFFFF) begin
                        r_count <= r_count + 16'h0001;
                    end
                end
            end
        end
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic r_err;

    // Sticky until reset; clear deliberately leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_legal) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking scoreboard bench for instr_encoder (ADDR_WIDTH=2).
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [4:0]  rd, rs1, rs2;
    logic [12:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_addr;
    logic [31:0] out_data;
    logic [15:0] count;
    logic        err;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sb_q [$];
    logic [1:0]  exp_addr = 2'd0;
    int          exp_cnt  = 0;

    instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_enc(input logic [2:0] k, input logic [4:0] d, input logic [4:0] s1,
                                              input logic [4:0] s2, input logic [12:0] im);
        logic [31:0] w;
        w = 32'h0000_0013;
        if (k == 3'd0) w = {im[11:0], s1, 3'b010, d, 7'h03};
        if (k == 3'd1) w = {im[11:5], s2, s1, 3'b010, im[4:0], 7'h23};
        if (k == 3'd2) w = {7'h00, s2, s1, 3'b000, d, 7'h33};
        if (k == 3'd3) w = {im[12], im[10:5], s2, s1, 3'b001, im[4:1], im[11], 7'h63};
        if (k == 3'd4) w = {im[11:0], s1, 3'b000, d, 7'h13};
        return w;
    endfunction

    function automatic logic model_legal(input logic [2:0] k, input logic [12:0] im);
`ifdef INSTR_ENC_RANGE_CHECK_EN
        return (k <= 3'd4) && !(k == 3'd3 && im[0]);
`else
        return 1'b1;
`endif
    endfunction

    // Scoreboard: push on accept, pop and compare on each output transfer.
    always @(negedge clk) begin
        if (!rst_n || clear) begin
            sb_q.delete();
            exp_addr = 2'd0;
            exp_cnt  = 0;
        end else begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_underflow: unexpected write addr=%0d data=%h", out_addr, out_data);
                end else begin
                    logic [31:0] e;
                    e = sb_q.pop_front();
                    if (out_data !== e || out_addr !== exp_addr) begin
                        n_bad++;
                        $display("FAIL sb_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                                 out_addr, out_data, exp_addr, e);
                    end
                end
                exp_addr = exp_addr + 2'd1;
                if (exp_cnt < 65535) exp_cnt++;
            end
            if (in_valid && in_ready && model_legal(in_kind, imm))
                sb_q.push_back(model_enc(in_kind, rd, rs1, rs2, imm));
        end
    end

    task automatic drive(input logic [2:0] k, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [12:0] im, output int waited);
        bit ok;
        ok = 0;
        waited = 0;
        in_kind = k; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
            waited++;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL drive_timeout: in_ready stayed 0 for kind=%0d", k);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 20 && out_valid; i++) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_drain: out_valid=%b required 0", tag, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_kind = 3'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 13'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp += 6;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: %b required 0", out_valid); end
        if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL rst_in_ready: %b required 0", in_ready); end
        if (out_addr !== 2'd0)  begin n_bad++; $display("FAIL rst_out_addr: %0d required 0", out_addr); end
        if (out_data !== 32'd0) begin n_bad++; $display("FAIL rst_out_data: %h required 0", out_data); end
        if (count !== 16'd0)    begin n_bad++; $display("FAIL rst_count: %0d required 0", count); end
        if (err !== 1'b0)       begin n_bad++; $display("FAIL rst_err: %b required 0", err); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rel_in_ready_early: %b required 0", in_ready); end
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rel_in_ready: %b required 1", in_ready); end
    endtask

    task automatic test_addi();
        int w;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(3'd4, 5'd1, 5'd0, 5'd0, 13'd5, w);
        @(negedge clk);
        n_cmp += 3;
        if (out_valid !== 1'b1)          begin n_bad++; $display("FAIL addi_valid: %b required 1", out_valid); end
        if (out_data !== 32'h0050_0093)  begin n_bad++; $display("FAIL addi_data: %h required 00500093", out_data); end
        if (out_addr !== 2'd0)           begin n_bad++; $display("FAIL addi_addr: %0d required 0", out_addr); end
        @(negedge clk);
        n_cmp += 2;
        if (count !== 16'd1)     begin n_bad++; $display("FAIL addi_count: %0d required 1", count); end
        if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL addi_idle: %b required 0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_encodings();
        int w, stalls;
        out_ready = 1'b1;
        drive(3'd3, 5'd31, 5'd1, 5'd2, 13'h1FF8, w);
        @(negedge clk);
        n_cmp++;
        if (out_data !== 32'hFE20_9CE3) begin n_bad++; $display("FAIL bne_data: %h required FE209CE3", out_data); end
        @(posedge clk); #1;
        drive(3'd1, 5'd31, 5'd2, 5'd3, 13'd12, w);
        @(negedge clk);
        n_cmp++;
        if (out_data !== 32'h0031_2623) begin n_bad++; $display("FAIL sw_data: %h required 00312623", out_data); end
        @(posedge clk); #1;
        stalls = 0;
        drive(3'd0, 5'd5, 5'd6, 5'd7, 13'h1FFF, w); stalls += w;
        drive(3'd2, 5'd7, 5'd8, 5'd9, 13'h0ABC, w); stalls += w;
        drive(3'd4, 5'd10, 5'd11, 5'd12, 13'h0800, w); stalls += w;
        drive(3'd3, 5'd4, 5'd13, 5'd14, 13'h0011, w); stalls += w;
        drive(3'd6, 5'd1, 5'd2, 5'd3, 13'd4, w); stalls += w;
        drive(3'd7, 5'd1, 5'd2, 5'd3, 13'd4, w); stalls += w;
        drive(3'd1, 5'd9, 5'd31, 5'd30, 13'h0FFF, w); stalls += w;
        n_cmp++;
        if (stalls !== 0) begin n_bad++; $display("FAIL stream_stalls: %0d required 0", stalls); end
        wait_drain("enc");
        @(negedge clk);
        n_cmp += 2;
        if (count !== 16'(exp_cnt)) begin n_bad++; $display("FAIL enc_count: %0d required %0d", count, exp_cnt); end
`ifdef INSTR_ENC_RANGE_CHECK_EN
        if (err !== 1'b1) begin n_bad++; $display("FAIL enc_err: %b required 1", err); end
`else
        if (err !== 1'b0) begin n_bad++; $display("FAIL enc_err: %b required 0", err); end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int w;
        pulse_clear();
        out_ready = 1'b0;
        drive(3'd2, 5'd1, 5'd2, 5'd3, 13'd0, w);
        drive(3'd0, 5'd4, 5'd5, 5'd0, 13'd8, w);
        in_kind = 3'd4; rd = 5'd2; rs1 = 5'd2; rs2 = 5'd0; imm = 13'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp += 3;
            if (in_ready !== 1'b0)          begin n_bad++; $display("FAIL bp_in_ready: %b required 0", in_ready); end
            if (out_data !== 32'h0031_00B3) begin n_bad++; $display("FAIL bp_hold_data: %h required 003100B3", out_data); end
            if (out_addr !== 2'd0)          begin n_bad++; $display("FAIL bp_hold_addr: %0d required 0", out_addr); end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_data !== 32'h0031_00B3) begin n_bad++; $display("FAIL bp_first: %h required 003100B3", out_data); end
        @(negedge clk);
        n_cmp += 2;
        if (out_data !== 32'h0082_A203) begin n_bad++; $display("FAIL bp_second: %h required 0082A203", out_data); end
        if (out_addr !== 2'd1)          begin n_bad++; $display("FAIL bp_second_addr: %0d required 1", out_addr); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain("bp");
        @(posedge clk); #1;
    endtask

    task automatic test_wrap_and_clear();
        int w;
        logic [1:0] seq [6];
        seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        pulse_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(3'd4, 5'd3, 5'd3, 5'd0, 13'(i + 20), w);
            @(negedge clk);
            n_cmp++;
            if (out_addr !== seq[i]) begin n_bad++; $display("FAIL wrap_addr%0d: %0d required %0d", i, out_addr, seq[i]); end
            @(posedge clk); #1;
        end
        in_kind = 3'd4; rd = 5'd6; rs1 = 5'd0; rs2 = 5'd0; imm = 13'd99;
        in_valid = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL clr_in_ready: %b required 0", in_ready); end
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp += 3;
        if (out_valid !== 1'b1)         begin n_bad++; $display("FAIL clr_valid: %b required 1", out_valid); end
        if (out_addr !== 2'd0)          begin n_bad++; $display("FAIL clr_addr: %0d required 0", out_addr); end
        if (out_data !== 32'h0630_0313) begin n_bad++; $display("FAIL clr_data: %h required 06300313", out_data); end
        @(negedge clk);
        n_cmp++;
        if (count !== 16'd1) begin n_bad++; $display("FAIL clr_count: %0d required 1", count); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int w;
        out_ready = 1'b0;
        drive(3'd2, 5'd1, 5'd1, 5'd1, 13'd0, w);
        drive(3'd2, 5'd2, 5'd2, 5'd2, 13'd0, w);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_full: %b required 1", out_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_async: %b required 0", out_valid); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp += 2;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: %b required 0", out_valid); end
            if (count !== 16'd0)    begin n_bad++; $display("FAIL mid_count: %0d required 0", count); end
        end
        n_cmp++;
        if (sb_q.size() != 0) begin n_bad++; $display("FAIL sb_leftover: %0d entries required 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_encodings();
        test_back_to_back();
        test_wrap_and_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
